// File: rtl/res_buffer_pkg.sv
// Shared layer package for the residual path.
// Holds the activation width / channel count defaults and the residual
// vector type used by res_buffer and the BN-residual adder, plus a helper
// that sizes occupancy counters for a power-of-two buffer depth.
package res_buffer_pkg;

  localparam int RES_DATA_WIDTH = 16;
  localparam int RES_FM_DEPTH   = 64;

  // One residual pixel vector: FM_DEPTH channels of signed activations.
  typedef logic signed [RES_FM_DEPTH-1:0][RES_DATA_WIDTH-1:0] res_vec_t;

  // Counter width able to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/res_buffer_if.sv
// Residual buffer data interface.
// master: layer-input producer / consumer side (drives wr_valid, wr_data,
//         rd_req; receives res, res_valid).
// slave : the residual buffer itself.
interface res_buffer_if
  import res_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = RES_DATA_WIDTH,
  parameter int FM_DEPTH   = RES_FM_DEPTH
) ();

  logic                                      wr_valid;
  logic signed [FM_DEPTH-1:0][DATA_WIDTH-1:0] wr_data;
  logic                                      rd_req;
  logic signed [FM_DEPTH-1:0][DATA_WIDTH-1:0] res;
  logic                                      res_valid;

  modport master (
    output wr_valid, wr_data, rd_req,
    input  res, res_valid
  );

  modport slave (
    input  wr_valid, wr_data, rd_req,
    output res, res_valid
  );

endinterface

// File: rtl/res_buffer_ctrl.sv
// Residual buffer control: circular FIFO pointers, occupancy count,
// full/empty status, sticky overflow/underflow flags and accept logic.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   wr_valid, rd_req     write request / pop request
//   flush, err_clr       synchronous frame restart / sticky flag clear
//   wr_en, wr_ptr        accepted write and its slot
//   rd_en, rd_ptr        accepted pop and its slot
//   count, full, empty   registered occupancy status
//   overflow, underflow  sticky error flags
module res_buffer_ctrl
  import res_buffer_pkg::*;
#(
  parameter  int BUF_DEPTH = 16,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = cnt_width(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  input  logic             rd_req,
  input  logic             flush,
  input  logic             err_clr,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             rd_en,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push, pop, ovf_ev, udf_ev;

  always_comb begin
    // Flush masks every request, so it also suppresses error events.
    pop    = !flush && rd_req && !empty_q;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    // Empty never admits a pop, so there is no write-to-read bypass.
    push   = !flush && wr_valid && (!full_q || pop);
    ovf_ev = !flush && wr_valid && !push;
    udf_ev = !flush && rd_req && empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // BUF_DEPTH is a power of two, so natural pointer overflow wraps to 0.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_W'(BUF_DEPTH));
    empty_d = (count_d == '0);

    // A new error event beats a simultaneous clear.
    ovf_d = (ovf_q && !err_clr) || ovf_ev;
    udf_d = (udf_q && !err_clr) || udf_ev;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_en     = push;
  assign wr_ptr    = wr_ptr_q;
  assign rd_en     = pop;
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: rtl/res_buffer.sv
// Residual buffer: retains layer-input pixel vectors in a circular FIFO
// and replays them, one per consumer request, to the BN-residual adder.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   bus (slave)          wr_valid/wr_data in, rd_req in, res/res_valid out
//   flush                synchronous frame restart (drops stored vectors)
//   err_clr              clears sticky overflow/underflow
//   count, full, empty   occupancy status
//   overflow, underflow  sticky error flags
// BUF_DEPTH must be a power of two and at least 2.
module res_buffer
  import res_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = RES_DATA_WIDTH,
  parameter  int FM_DEPTH   = RES_FM_DEPTH,
  parameter  int BUF_DEPTH  = 16,
  localparam int PTR_W      = $clog2(BUF_DEPTH),
  localparam int CNT_W      = cnt_width(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  res_buffer_if.slave      bus,
  input  logic             flush,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  typedef logic signed [FM_DEPTH-1:0][DATA_WIDTH-1:0] vec_t;

  logic             wr_en, rd_en;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  vec_t mem [BUF_DEPTH];
  vec_t res_q, res_d;
  logic res_valid_q, res_valid_d;

  res_buffer_ctrl #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (bus.wr_valid),
    .rd_req    (bus.rd_req),
    .flush     (flush),
    .err_clr   (err_clr),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .rd_en     (rd_en),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage is never reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.wr_data;
  end

  // When full with simultaneous push/pop, wr_ptr == rd_ptr; the read sees
  // the old entry because the array updates at the same edge.
  always_comb begin
    res_d       = res_q;
    res_valid_d = rd_en;
    if (rd_en) res_d = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_res_buffer.sv
// Testbench for res_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_res_buffer;
  import res_buffer_pkg::*;

  localparam int DW    = 16;
  localparam int FD    = 64;
  localparam int BD    = 16;
  localparam int CW    = $clog2(BD) + 1;
  localparam int RES_W = DW * FD;

  typedef logic signed [FD-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          err_clr;
  logic [CW-1:0] count;
  logic          full, empty, overflow, underflow;

  res_buffer_if #(.DATA_WIDTH(DW), .FM_DEPTH(FD)) bus ();

  res_buffer #(
    .DATA_WIDTH(DW),
    .FM_DEPTH  (FD),
    .BUF_DEPTH (BD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .flush     (flush),
    .err_clr   (err_clr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  vec_t m_q[$];
  vec_t m_res;
  bit   m_rv, m_ovf, m_udf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_res(input string tag);
    logic [RES_W-1:0] o, e;
    o = bus.res;
    e = m_res;
    for (int i = 0; i < RES_W / 64; i++)
      check($sformatf("%s res[%0d]", tag, i), o[i*64 +: 64], e[i*64 +: 64]);
  endtask

  task automatic check_all(input string tag);
    check_res(tag);
    check({tag, " res_valid"}, 64'(bus.res_valid), 64'(m_rv));
    check({tag, " count"},     64'(count),         64'(m_q.size()));
    check({tag, " full"},      64'(full),          64'(m_q.size() == BD));
    check({tag, " empty"},     64'(empty),         64'(m_q.size() == 0));
    check({tag, " overflow"},  64'(overflow),      64'(m_ovf));
    check({tag, " underflow"}, 64'(underflow),     64'(m_udf));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_res = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // One clock of FIFO behaviour, computed from the buffer's rules.
  task automatic model_cycle(input bit wv, input vec_t wd, input bit rr, input bit fl, input bit ec);
    int sz;
    bit pop, push, oev, uev;
    sz = m_q.size();
    pop = 0; push = 0; oev = 0; uev = 0;
    if (fl) begin
      m_q.delete();
      m_rv = 1'b0;
    end else begin
      pop  = rr && (sz > 0);
      push = wv && ((sz < BD) || pop);
      oev  = wv && !push;
      uev  = rr && (sz == 0);
      m_rv = pop;
      if (pop)  m_res = m_q.pop_front();
      if (push) m_q.push_back(wd);
    end
    if (ec) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (oev) m_ovf = 1'b1;
    if (uev) m_udf = 1'b1;
  endtask

  task automatic step(input bit wv, input vec_t wd, input bit rr, input bit fl, input bit ec,
                      input string tag);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_req   = rr;
    flush        = fl;
    err_clr      = ec;
    @(posedge clk);
    model_cycle(wv, wd, rr, fl, ec);
    #1;
    check_all(tag);
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    flush        = 1'b0;
    err_clr      = 1'b0;
  endtask

  function automatic vec_t mkvec(input int k);
    vec_t v;
    for (int c = 0; c < FD; c++) v[c] = DW'(16 * k + c);
    return v;
  endfunction

  function automatic vec_t rndvec();
    vec_t v;
    for (int c = 0; c < FD; c++) v[c] = DW'($urandom);
    return v;
  endfunction

  initial begin
    vec_t z;
    int   k;
    int   wthr;
    z = '0;
    rstn         = 1'b0;
    flush        = 1'b0;
    err_clr      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rstn = 1'b1;

    // Three vectors in, three out, with 1-cycle latency.
    for (int i = 0; i < 3; i++) step(1, mkvec(i), 0, 0, 0, "basic_wr");
    for (int i = 0; i < 3; i++) step(0, z, 1, 0, 0, "basic_rd");

    // Fill, overflow on the 17th, drain in order.
    for (int i = 0; i < BD; i++) step(1, mkvec(10 + i), 0, 0, 0, "fill");
    step(1, mkvec(99), 0, 0, 0, "overflow");
    for (int i = 0; i < BD; i++) step(0, z, 1, 0, 0, "drain");
    step(0, z, 0, 0, 1, "err_clr");

    // Full with simultaneous push and pop across pointer wrap.
    k = 200;
    for (int i = 0; i < BD; i++) begin step(1, mkvec(k), 0, 0, 0, "fill2"); k++; end
    for (int i = 0; i < 40; i++) begin step(1, mkvec(k), 1, 0, 0, "full_rw"); k++; end
    for (int i = 0; i < BD; i++) step(0, z, 1, 0, 0, "drain2");

    // Pop on empty with a same-cycle write: no bypass.
    step(1, mkvec(300), 1, 0, 0, "no_bypass");
    step(0, z, 1, 0, 0, "no_bypass_pop");
    step(0, z, 0, 0, 1, "err_clr2");

    // Flush discards stored vectors.
    for (int i = 0; i < 5; i++) step(1, mkvec(400 + i), 0, 0, 0, "pre_flush");
    step(1, mkvec(499), 1, 1, 0, "flush");
    step(1, mkvec(500), 0, 0, 0, "post_flush_wr");
    step(0, z, 1, 0, 0, "post_flush_rd");
    step(0, z, 1, 0, 0, "underflow_set");
    step(0, z, 1, 0, 1, "err_vs_clr");
    step(0, z, 0, 0, 1, "err_clr3");

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 8; i++) step(1, mkvec(600 + i), 0, 0, 0, "pre_rst");
    step(0, z, 1, 0, 0, "pre_rst_pop");
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rstn = 1'b1;
    step(0, z, 1, 0, 0, "post_rst_rd");
    step(0, z, 0, 0, 1, "err_clr4");

    // Randomized traffic: write-heavy, then balanced, then read-heavy.
    for (int i = 0; i < 900; i++) begin
      wthr = (i < 300) ? 85 : (i < 600) ? 50 : 20;
      step(($urandom % 100) < wthr, rndvec(), ($urandom % 100) < 50,
           ($urandom % 60) == 0, ($urandom % 25) == 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/res_buffer.md
RES_BUFFER -- requirements
Module: res_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one residual activation.
REQ-002 Parameter FM_DEPTH, default 64, channels per residual pixel vector.
REQ-003 Parameter BUF_DEPTH, default 16, pixel vectors stored; power of two, at least 2.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid  input  1  layer-input pixel vector present on wr_data this cycle.
REQ-007 wr_data  input  FM_DEPTH x DATA_WIDTH signed  layer-input activations to retain as residual.
REQ-008 rd_req  input  1  consumer's data_in_valid; requests the next residual vector.
REQ-009 flush  input  1  synchronous frame restart; discards all stored vectors.
REQ-010 err_clr  input  1  synchronous clear of sticky error flags.
REQ-011 res  output  FM_DEPTH x DATA_WIDTH signed, registered  residual vector to the BN-residual adder.
REQ-012 res_valid  output  1, registered  one-cycle pulse marking a newly loaded res.
REQ-013 count  output  clog2(BUF_DEPTH)+1  number of stored vectors.
REQ-014 full, empty  output  1 each  count==BUF_DEPTH, count==0.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Buffer SHALL be a circular FIFO of BUF_DEPTH vectors with write pointer, read pointer and count; pointers wrap from BUF_DEPTH-1 to 0.
REQ-017 Write accepted when wr_valid=1 and (full=0 or pop accepted same cycle); wr_data stored at write pointer, pointer advances.
REQ-018 Pop accepted when rd_req=1 and empty=0; entry at read pointer SHALL appear on res at the next rising edge (latency 1), read pointer advances.
REQ-019 res_valid SHALL be 1 in exactly the cycle after each accepted pop, else 0.
REQ-020 res SHALL hold its last loaded value until the next accepted pop.
REQ-021 Accepted write and pop in the same cycle SHALL leave count unchanged, including at full and at count==1.
REQ-022 No write-to-read bypass: rd_req with empty=1 SHALL be rejected even if wr_valid=1 that cycle.
REQ-023 Rejected write (full, no pop) SHALL drop wr_data and set overflow.
REQ-024 Rejected pop (empty) SHALL leave res unchanged, keep res_valid 0 next cycle, and set underflow.
REQ-025 Error flags SHALL stay set until err_clr=1 or reset; an error event in the same cycle as err_clr SHALL win (flag remains 1).
REQ-026 flush=1 SHALL zero pointers and count and ignore wr_valid and rd_req that cycle; res, res_valid and error flags are unaffected by flush except res_valid=0 next cycle.
REQ-027 count, full, empty SHALL be registered and consistent with pointers every cycle.

Reset
REQ-028 While rstn=0: res all zero, res_valid 0, count 0, empty 1, full 0, overflow 0, underflow 0, both pointers 0.
REQ-029 Storage array SHALL NOT be reset; it is only read after being written.
REQ-030 Reset asserted mid-operation SHALL discard all stored vectors immediately; first cycle after release behaves as empty.

Structure
REQ-031 DATA_WIDTH, FM_DEPTH defaults and a residual-vector typedef SHALL live in the shared layer package, reused by the BN-residual adder.
REQ-032 One sub-module res_buffer_ctrl SHALL hold pointers, count, flags and accept logic; storage and res register stay in res_buffer.

Verification
REQ-033 Write vectors V0..V2 (channel c = 16*k+c), then rd_req three cycles -> res=V0,V1,V2 one cycle after each rd_req, res_valid pulses 3 times, empty=1 at end.
REQ-034 Fill 16 vectors, write a 17th -> full=1, overflow=1, 17th dropped; 16 pops return first 16 in order.
REQ-035 At full, wr_valid and rd_req together for 40 cycles -> count stays 16, order preserved across pointer wrap.
REQ-036 rd_req with empty=1 and wr_valid=1 same cycle -> underflow=1, res unchanged, res_valid 0, count=1 after.
REQ-037 Load 5 vectors, flush, then write W and pop -> res=W, count=0; then err_clr clears sticky flags.
REQ-038 Assert rstn=0 with count=7 and res nonzero -> res=0, count=0, empty=1 immediately; rd_req after release sets underflow.
